// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types and defaults for the up/down sweep controller.
package updown_sweep_ctrl_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Drives an external hold-less up/down counter through repeated lo->hi->lo sweeps.
// Holding is done by reloading the counter with its own value.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] nsweep,
  input  logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d,
  output logic         cnt_ld,
  output logic         cnt_und,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_e         state_q, state_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   nsweep_q, nsweep_d;
  logic [W-1:0]   sweeps_q, sweeps_d;
  logic [W-1:0]   sweeps_inc;
  logic           busy_q, done_q, err_q;
  logic           err_d;

  assign sweeps_inc = sweeps_q + {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    nsweep_d = nsweep_q;
    sweeps_d = sweeps_q;
    err_d    = 1'b0;
    cnt_ld   = 1'b1;
    cnt_d    = cnt_q;
    cnt_und  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (nsweep != '0)) begin
            lo_d     = lo;
            hi_d     = hi;
            nsweep_d = nsweep;
            sweeps_d = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d   = lo_q;
          state_d = UP;
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Turn around on the hi sample itself so hi is never overshot.
          cnt_ld = 1'b0;
          if (cnt_q == hi_q) begin
            cnt_und = 1'b0;
            state_d = DOWN;
          end else begin
            cnt_und = 1'b1;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == lo_q) begin
          sweeps_d = sweeps_inc;
          if (sweeps_inc == nsweep_q) begin
            state_d = DONE;
          end else begin
            cnt_ld  = 1'b0;
            cnt_und = 1'b1;
            state_d = UP;
          end
        end else begin
          cnt_ld  = 1'b0;
          cnt_und = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      nsweep_q <= '0;
      sweeps_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      nsweep_q <= nsweep_d;
      sweeps_q <= sweeps_d;
      // Status flags are registered from the next state so they line up with it.
      busy_q   <= (state_d == LOAD) || (state_d == UP) || (state_d == DOWN);
      done_q   <= (state_d == DONE);
      err_q    <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench: the controller drives a behavioural up/down counter.
module tb_updown_sweep_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [W-1:0] lo, hi, nsweep;
  logic [W-1:0] cnt_q, cnt_d;
  logic         cnt_ld, cnt_und, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .nsweep(nsweep), .cnt_q(cnt_q),
    .cnt_d(cnt_d), .cnt_ld(cnt_ld), .cnt_und(cnt_und),
    .busy(busy), .done(done), .err(err)
  );

  // Hold-less up/down counter with its own synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_d;
    else if (cnt_und) cnt_q <= cnt_q + 4'd1;
    else             cnt_q <= cnt_q - 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [W-1:0] exp1 [7];
    logic [W-1:0] exp2 [7];
    exp1 = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    exp2 = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; nsweep = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_cnt", cnt_q, 0);
    chk("reset_hold_ld", cnt_ld, 1);
    chk("reset_hold_d", cnt_d, 0);

    // Single sweep 2..5..2, with a stray start mid-job.
    lo = 4'd2; hi = 4'd5; nsweep = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_load_busy", busy, 1);
    chk("s1_load_ld", cnt_ld, 1);
    chk("s1_load_d", cnt_d, 2);
    tick();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("s1_trace%0d", k), cnt_q, exp1[k]);
      chk($sformatf("s1_busy%0d", k), busy, 1);
      chk($sformatf("s1_done%0d", k), done, 0);
      chk($sformatf("s1_err%0d", k), err, 0);
      if (k == 3) begin
        start = 1'b1; lo = 4'd0; hi = 4'd9; nsweep = 4'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("s1_done_pulse", done, 1);
    chk("s1_done_busy", busy, 0);
    chk("s1_done_cnt", cnt_q, 2);
    tick();
    chk("s1_after_done", done, 0);
    tick();
    chk("s1_held_cnt", cnt_q, 2);
    chk("s1_held_err", err, 0);

    // Three sweeps between 0 and 1.
    lo = 4'd0; hi = 4'd1; nsweep = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("s3_trace%0d", k), cnt_q, exp2[k]);
      chk($sformatf("s3_done%0d", k), done, 0);
      tick();
    end
    chk("s3_done_pulse", done, 1);
    chk("s3_done_cnt", cnt_q, 0);
    tick();
    chk("s3_after_done", done, 0);

    // Rejected starts.
    lo = 4'd5; hi = 4'd5; nsweep = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_eq_err", err, 1);
    chk("rej_eq_busy", busy, 0);
    chk("rej_eq_cnt", cnt_q, 0);
    tick();
    chk("rej_eq_err_end", err, 0);
    chk("rej_eq_busy2", busy, 0);
    lo = 4'd1; hi = 4'd3; nsweep = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_n0_err", err, 1);
    chk("rej_n0_busy", busy, 0);
    tick();
    chk("rej_n0_err_end", err, 0);
    chk("rej_n0_cnt", cnt_q, 0);

    // Abort during UP at cnt_q=4.
    lo = 4'd1; hi = 4'd9; nsweep = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ab_pre_cnt", cnt_q, 4);
    abort = 1'b1;
    #1;
    chk("ab_hold_ld", cnt_ld, 1);
    chk("ab_hold_d", cnt_d, 4);
    tick();
    abort = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ab_cnt%0d", k), cnt_q, 4);
      chk($sformatf("ab_busy%0d", k), busy, 0);
      chk($sformatf("ab_done%0d", k), done, 0);
      tick();
    end

    // Reset while sweeping down.
    lo = 4'd2; hi = 4'd5; nsweep = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("rs_pre_cnt", cnt_q, 4);
    chk("rs_pre_und", cnt_und, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_err", err, 0);
    chk("rs_cnt", cnt_q, 0);
    tick(); tick();
    chk("rs_held_cnt", cnt_q, 0);
    chk("rs_held_ld", cnt_ld, 1);
    chk("rs_held_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
